// File: rtl/cpu_controller.sv
`timescale 1ns/1ps
// cpu_controller: instruction register, decoder and Moore control FSM for the
// simple 16-bit datapath (register file, A/B/C, shifter, ALU, status).
// Optional feature macro: CPU_CTRL_ILLEGAL_TRAP_EN -- when defined, an illegal
// instruction traps into HALT (illegal=1, w=0) until reset; when undefined an
// illegal instruction is a NOP and illegal is tied low.
module cpu_controller #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       in,
  input  logic              load,
  input  logic              s,
  output logic              w,
  output logic [DATA_W-1:0] datapath_in,
  output logic [DATA_W-1:0] sximm5,
  output logic              vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic              write,
  output logic [2:0]        writenum,
  output logic [2:0]        readnum,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic              illegal
);

  localparam int unsigned IR_W  = 16;
  localparam int unsigned IMM8  = 8;
  localparam int unsigned IMM5  = 5;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A,
    S_GET_B, S_COMPUTE, S_WRITE_REG, S_HALT
  } state_t;

  state_t          state, state_nx;
  logic [IR_W-1:0] ir, ir_nx;

  // Decode of the held instruction (used by DECODE/COMPUTE transitions)
  logic [2:0] opcode;
  logic [1:0] op;
  logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

  // Next-cycle output values, registered below
  logic       nx_w, nx_vsel, nx_loada, nx_loadb, nx_loadc, nx_loads;
  logic       nx_asel, nx_bsel, nx_write;
  logic [2:0] nx_writenum, nx_readnum;
  logic [1:0] nx_shift, nx_aluop;

  // Immediates are pure wiring off the instruction register
  assign datapath_in = {{(DATA_W-IMM8){ir[IMM8-1]}}, ir[IMM8-1:0]};
  assign sximm5      = {{(DATA_W-IMM5){ir[IMM5-1]}}, ir[IMM5-1:0]};

  // Instruction class decode from the current IR
  always_comb begin
    opcode     = ir[15:13];
    op         = ir[12:11];
    is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    is_alu     = (opcode == 3'b101);
    is_cmp     = is_alu && (op == 2'b01);
    is_mvn     = is_alu && (op == 2'b11);
  end

  // Next IR, next state and the Moore outputs of the next state
  always_comb begin
    ir_nx = ir;
    if ((state == S_WAIT) && load) ir_nx = in;

    state_nx = state;
    case (state)
      S_WAIT:      if (s) state_nx = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)                state_nx = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_nx = S_GET_B;
        else if (is_alu)               state_nx = S_GET_A;
        else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          state_nx = S_HALT;
`else
          state_nx = S_WAIT;
`endif
        end
      end
      S_GET_A:     state_nx = S_GET_B;
      S_GET_B:     state_nx = S_COMPUTE;
      S_COMPUTE:   state_nx = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_IMM: state_nx = S_WAIT;
      S_WRITE_REG: state_nx = S_WAIT;
      S_HALT: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        state_nx = S_HALT;
`else
        state_nx = S_WAIT;
`endif
      end
      default:     state_nx = S_WAIT;
    endcase

    nx_w        = 1'b0;
    nx_vsel     = 1'b0;
    nx_loada    = 1'b0;
    nx_loadb    = 1'b0;
    nx_loadc    = 1'b0;
    nx_loads    = 1'b0;
    nx_asel     = 1'b0;
    nx_bsel     = 1'b0;
    nx_write    = 1'b0;
    nx_readnum  = ir_nx[10:8];
    nx_writenum = ir_nx[10:8];
    nx_shift    = 2'b00;
    nx_aluop    = 2'b00;
    case (state_nx)
      S_WAIT:      nx_w = 1'b1;
      S_WRITE_IMM: begin
        nx_write    = 1'b1;
        nx_vsel     = 1'b1;
        nx_writenum = ir_nx[10:8];
      end
      S_GET_A: begin
        nx_loada   = 1'b1;
        nx_readnum = ir_nx[10:8];
      end
      S_GET_B: begin
        nx_loadb   = 1'b1;
        nx_readnum = ir_nx[2:0];
      end
      S_COMPUTE: begin
        nx_loadc = 1'b1;
        nx_shift = ir_nx[4:3];
        nx_bsel  = 1'b0;
        if (ir_nx[15:13] == 3'b101) nx_aluop = ir_nx[12:11];
        else                        nx_asel  = 1'b1;
        nx_loads = (ir_nx[15:13] == 3'b101) && (ir_nx[12:11] == 2'b01);
      end
      S_WRITE_REG: begin
        nx_write    = 1'b1;
        nx_vsel     = 1'b0;
        nx_writenum = ir_nx[7:5];
      end
      default: ;
    endcase
  end

  // State, IR and registered outputs; reset forces WAIT with all strobes low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_WAIT;
      ir       <= '0;
      w        <= 1'b1;
      vsel     <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      write    <= 1'b0;
      writenum <= 3'd0;
      readnum  <= 3'd0;
      shift    <= 2'b00;
      ALUop    <= 2'b00;
    end else begin
      state    <= state_nx;
      ir       <= ir_nx;
      w        <= nx_w;
      vsel     <= nx_vsel;
      loada    <= nx_loada;
      loadb    <= nx_loadb;
      loadc    <= nx_loadc;
      loads    <= nx_loads;
      asel     <= nx_asel;
      bsel     <= nx_bsel;
      write    <= nx_write;
      writenum <= nx_writenum;
      readnum  <= nx_readnum;
      shift    <= nx_shift;
      ALUop    <= nx_aluop;
    end
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  // Sticky trap flag, high exactly while parked in HALT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal <= 1'b0;
    else       illegal <= (state_nx == S_HALT);
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
`timescale 1ns/1ps
// Directed bench for cpu_controller with a small behavioural datapath model
// (register file, A/B/C, shifter, ALU, Z flag) driven by the controller strobes.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset, load, s;
  logic [15:0] in;
  logic        w, vsel, loada, loadb, loadc, loads, asel, bsel, write, illegal;
  logic [15:0] datapath_in, sximm5;
  logic [2:0]  writenum, readnum;
  logic [1:0]  shift, ALUop;

  int total = 0;
  int bad   = 0;

  cpu_controller #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .datapath_in(datapath_in), .sximm5(sximm5), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .write(write), .writenum(writenum),
    .readnum(readnum), .shift(shift), .ALUop(ALUop), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Datapath model
  logic [15:0] rf [8];
  logic [15:0] ra, rb, rc, sh_b, ain, bin, alu;
  logic        z;
  int          wr_cnt = 0;

  always_comb begin
    case (shift)
      2'b00:   sh_b = rb;
      2'b01:   sh_b = {rb[14:0], 1'b0};
      2'b10:   sh_b = {1'b0, rb[15:1]};
      default: sh_b = {rb[15], rb[15:1]};
    endcase
    ain = asel ? 16'd0 : ra;
    bin = bsel ? sximm5 : sh_b;
    case (ALUop)
      2'b00:   alu = ain + bin;
      2'b01:   alu = ain - bin;
      2'b10:   alu = ain & bin;
      default: alu = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (loada === 1'b1) ra <= rf[readnum];
    if (loadb === 1'b1) rb <= rf[readnum];
    if (loadc === 1'b1) rc <= alu;
    if (loads === 1'b1) z  <= (alu == 16'd0);
    if (write === 1'b1) begin
      rf[writenum] <= vsel ? datapath_in : rc;
      wr_cnt       <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] strb();
    return {w, loada, loadb, loadc, loads, write, vsel, asel, bsel};
  endfunction

  task automatic load_ir(input logic [15:0] v);
    @(negedge clk); in = v; load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // Pulse s across one rising edge; returns at the negedge after it (DECODE)
  task automatic start();
    s = 1'b1;
    @(negedge clk); s = 1'b0;
  endtask

  // Run an instruction and check w is low one edge before completion, high at it
  task automatic run(input logic [15:0] v, input int edges, input string tag);
    load_ir(v);
    start();
    repeat (edges - 1) @(negedge clk);
    check({tag, "_busy"}, 32'(w), 32'(1'b0));
    @(negedge clk);
    check({tag, "_done"}, 32'(w), 32'(1'b1));
  endtask

  int snap;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_strobes", 32'(strb()), 32'(9'b100000000));
    check("rst_illegal", 32'(illegal), 32'(1'b0));
    check("rst_misc", 32'({readnum, writenum, shift, ALUop, datapath_in}), 32'(0));
    reset = 1'b0;

    // Reset during GET_A of an ADD
    load_ir(16'hA148);
    start();
    @(negedge clk);
    check("mid_get_a", 32'(strb()), 32'(9'b010000000));
    check("mid_get_a_rd", 32'(readnum), 32'(3'd1));
    snap = wr_cnt;
    #2 reset = 1'b1;
    #1 check("rst_async", 32'(strb()), 32'(9'b100000000));
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_no_write", 32'(wr_cnt), 32'(snap));
    check("rst_wait", 32'(strb()), 32'(9'b100000000));
    check("rst_ir", 32'(datapath_in), 32'(16'h0000));

    // MOV R0,#7
    load_ir(16'hD007);
    check("imm7_dpin", 32'(datapath_in), 32'(16'h0007));
    start();
    @(negedge clk);
    check("imm7_wr", 32'(strb()), 32'(9'b000001100));
    check("imm7_wn", 32'(writenum), 32'(3'd0));
    @(negedge clk);
    check("imm7_done", 32'(w), 32'(1'b1));
    check("r0", 32'(rf[0]), 32'(16'd7));

    // MOV R1,#2
    run(16'hD102, 2, "imm2");
    check("r1", 32'(rf[1]), 32'(16'd2));

    // ADD R2,R1,R0,LSL#1
    load_ir(16'hA148);
    check("add_sx5", 32'(sximm5), 32'(16'h0008));
    check("add_dpin", 32'(datapath_in), 32'(16'h0048));
    start();
    check("add_decode", 32'(strb()), 32'(9'b000000000));
    @(negedge clk);
    check("add_get_a", 32'({strb(), readnum}), 32'({9'b010000000, 3'd1}));
    @(negedge clk);
    check("add_get_b", 32'({strb(), readnum}), 32'({9'b001000000, 3'd0}));
    @(negedge clk);
    check("add_comp", 32'({strb(), shift, ALUop}), 32'({9'b000100000, 2'b01, 2'b00}));
    @(negedge clk);
    check("add_wreg", 32'({strb(), writenum}), 32'({9'b000001000, 3'd2}));
    @(negedge clk);
    check("add_done", 32'(w), 32'(1'b1));
    check("r2", 32'(rf[2]), 32'(16'd16));

    // CMP R0,R0
    load_ir(16'hA800);
    snap = wr_cnt;
    start();
    repeat (3) @(negedge clk);
    check("cmp_comp", 32'({strb(), ALUop}), 32'({9'b000110000, 2'b01}));
    @(negedge clk);
    check("cmp_done", 32'(strb()), 32'(9'b100000000));
    check("cmp_no_write", 32'(wr_cnt), 32'(snap));
    check("cmp_z", 32'(z), 32'(1'b1));

    // MVN R3,R0 and MOV R4,R0
    run(16'hB860, 4, "mvn");
    check("r3", 32'(rf[3]), 32'(16'hFFF8));
    run(16'hC080, 4, "movr");
    check("r4", 32'(rf[4]), 32'(16'd7));

    // AND R5,R1,R0 with a stray load pulse mid-instruction
    load_ir(16'hB1A0);
    start();
    @(negedge clk); in = 16'hFFFF; load = 1'b1;
    @(negedge clk); load = 1'b0; in = 16'h0000;
    check("ign_load_ir", 32'(datapath_in), 32'(16'hFFA0));
    @(negedge clk);
    @(negedge clk);
    check("and_wn", 32'(writenum), 32'(3'd5));
    @(negedge clk);
    check("and_done", 32'(w), 32'(1'b1));
    check("r5", 32'(rf[5]), 32'(16'd2));

    // MOV R1,#-2
    load_ir(16'hD1FE);
    check("neg_dpin", 32'(datapath_in), 32'(16'hFFFE));
    check("neg_sx5", 32'(sximm5), 32'(16'hFFFE));
    start();
    repeat (2) @(negedge clk);
    check("r1_neg", 32'(rf[1]), 32'(16'hFFFE));

    // s held high restarts the same instruction
    load_ir(16'hD103);
    s = 1'b1;
    repeat (5) @(negedge clk);
    check("s_held_wr", 32'(strb()), 32'(9'b000001100));
    s = 1'b0;
    @(negedge clk);
    check("s_held_done", 32'(w), 32'(1'b1));
    check("r1_three", 32'(rf[1]), 32'(16'd3));

    // Illegal opcode 0x0000
    load_ir(16'h0000);
    snap = wr_cnt;
    start();
    check("ill_decode", 32'(w), 32'(1'b0));
    @(negedge clk);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    check("ill_halt", 32'({illegal, strb()}), 32'({1'b1, 9'b000000000}));
    s = 1'b1;
    repeat (5) @(negedge clk);
    s = 1'b0;
    check("ill_sticky", 32'({illegal, strb()}), 32'({1'b1, 9'b000000000}));
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("ill_reset", 32'({illegal, w}), 32'({1'b0, 1'b1}));
`else
    check("ill_nop", 32'({illegal, strb()}), 32'({1'b0, 9'b100000000}));
`endif
    check("ill_no_write", 32'(wr_cnt), 32'(snap));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
